// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache with 4-word lines and a zero-latency hit path.
// Optional hit/miss statistics counters are enabled by defining ICACHE_STATS_EN.
module instruction_cache #(
    parameter int unsigned INDEX_BITS = 3,
    parameter logic [31:0] NOP_INSTR  = 32'h00000013
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic [31:0]   PC,
    output logic [31:0]   instruction,
    output logic          instruction_mem_busywait,
    output logic          mem_read,
    output logic [27:0]   mem_address,
    input  logic [127:0]  mem_readdata,
    input  logic          mem_busywait
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]   hit_count,
    output logic [31:0]   miss_count
`endif
);

    localparam int unsigned LINES    = 1 << INDEX_BITS;
    localparam int unsigned TAG_BITS = 28 - INDEX_BITS;
    localparam logic [31:0] SENTINEL = 32'hFFFFFFFC;

    typedef enum logic [1:0] {StIdle, StMemRead, StUpdate} state_t;

    state_t                state_q, state_d;
    logic [LINES-1:0]      valid_q;
    logic [TAG_BITS-1:0]   tag_q  [LINES];
    logic [127:0]          data_q [LINES];
    logic [INDEX_BITS-1:0] miss_index_q;
    logic [TAG_BITS-1:0]   miss_tag_q;
    logic [127:0]          line_buf_q;

    logic [1:0]            offset;
    logic [INDEX_BITS-1:0] index;
    logic [TAG_BITS-1:0]   tag;
    logic                  sentinel;
    logic                  hit;
    logic                  start_miss;
    logic [31:0]           hit_word;

    assign offset   = PC[3:2];
    assign index    = PC[4 +: INDEX_BITS];
    assign tag      = PC[31:4+INDEX_BITS];
    assign sentinel = (PC == SENTINEL);
    assign hit      = valid_q[index] && (tag_q[index] == tag);
    assign hit_word = data_q[index][{offset, 5'b00000} +: 32];

    always_comb begin
        state_d                  = state_q;
        instruction              = NOP_INSTR;
        instruction_mem_busywait = 1'b0;
        mem_read                 = 1'b0;
        mem_address              = '0;
        start_miss               = 1'b0;
        case (state_q)
            StIdle: begin
                if (!sentinel) begin
                    if (hit) begin
                        instruction = hit_word;
                    end else begin
                        instruction_mem_busywait = 1'b1;
                        start_miss               = 1'b1;
                        state_d                  = StMemRead;
                    end
                end
            end
            StMemRead: begin
                mem_read                 = 1'b1;
                mem_address              = {miss_tag_q, miss_index_q};
                instruction_mem_busywait = 1'b1;
                if (!mem_busywait) begin
                    state_d = StUpdate;
                end
            end
            StUpdate: begin
                instruction_mem_busywait = 1'b1;
                state_d                  = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // While reset is held the cleared valid bits would otherwise look like a miss.
        if (RESET) begin
            instruction              = NOP_INSTR;
            instruction_mem_busywait = 1'b0;
            mem_read                 = 1'b0;
            mem_address              = '0;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= StIdle;
            valid_q      <= '0;
            miss_index_q <= '0;
            miss_tag_q   <= '0;
        end else begin
            state_q <= state_d;
            if (start_miss) begin
                miss_index_q <= index;
                miss_tag_q   <= tag;
            end
            if (state_q == StUpdate) begin
                valid_q[miss_index_q] <= 1'b1;
            end
        end
    end

    // Tag and data storage carry no reset; the valid bits alone qualify them.
    always_ff @(posedge CLK) begin
        if (state_q == StMemRead && !mem_busywait) begin
            line_buf_q <= mem_readdata;
        end
        if (state_q == StUpdate) begin
            tag_q[miss_index_q]  <= miss_tag_q;
            data_q[miss_index_q] <= line_buf_q;
        end
    end

`ifdef ICACHE_STATS_EN
    logic        count_hit;
    logic [31:0] hit_q, miss_q;

    assign count_hit  = (state_q == StIdle) && hit && !sentinel;
    assign hit_count  = hit_q;
    assign miss_count = miss_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else begin
            if (count_hit) begin
                hit_q <= hit_q + 32'd1;
            end
            if (start_miss) begin
                miss_q <= miss_q + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instruction_cache.sv
// Scoreboard bench for instruction_cache: fetch requests queue expected results, a
// negedge monitor counts stall cycles, checks refill addresses and compares on delivery.
module tb_instruction_cache;

    localparam logic [31:0] NOP      = 32'h00000013;
    localparam logic [31:0] SENTINEL = 32'hFFFFFFFC;
    localparam int unsigned BUSY     = 3;

    logic         CLK = 1'b0;
    logic         RESET;
    logic [31:0]  PC;
    logic [31:0]  instruction;
    logic         instruction_mem_busywait;
    logic         mem_read;
    logic [27:0]  mem_address;
    logic [127:0] mem_readdata;
    logic         mem_busywait;
`ifdef ICACHE_STATS_EN
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;
`endif

    instruction_cache dut (
        .CLK                      (CLK),
        .RESET                    (RESET),
        .PC                       (PC),
        .instruction              (instruction),
        .instruction_mem_busywait (instruction_mem_busywait),
        .mem_read                 (mem_read),
        .mem_address              (mem_address),
        .mem_readdata             (mem_readdata),
        .mem_busywait             (mem_busywait)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count                (hit_count),
        .miss_count               (miss_count)
`endif
    );

    always #5 CLK = ~CLK;

    // Memory: BUSY busy cycles per request, word k of line a = C0DE0000 | {a[11:0], k, 00}.
    int unsigned mem_cnt = 0;
    always @(posedge CLK) begin
        if (mem_read) mem_cnt <= mem_cnt + 1;
        else          mem_cnt <= 0;
    end
    assign mem_busywait = mem_read && (mem_cnt < BUSY);

    function automatic logic [127:0] line_of(input logic [27:0] a);
        logic [127:0] r;
        for (int k = 0; k < 4; k++) begin
            r[32*k +: 32] = 32'hC0DE0000 | {16'h0000, a[11:0], 2'(k), 2'b00};
        end
        return r;
    endfunction
    always_comb mem_readdata = line_of(mem_address);

    typedef struct {
        logic [31:0] instr;
        int          stalls;
        int          mem_cycles;
        logic [27:0] addr_a;
        logic [27:0] addr_b;
    } item_t;

    item_t exp_q[$];
    int    checks = 0;
    int    failures = 0;
    int    done_cnt = 0;
    int    stall_cnt = 0;
    int    mem_cyc = 0;
    logic  req = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Monitor: counts stalls while busywait is high, pops and compares when it drops.
    always @(negedge CLK) begin
        if (req && !RESET) begin
            if (instruction_mem_busywait) begin
                stall_cnt++;
                if (mem_read && exp_q.size() > 0) begin
                    check("mem_address", {4'h0, mem_address},
                          {4'h0, (mem_cyc < 4) ? exp_q[0].addr_a : exp_q[0].addr_b});
                    mem_cyc++;
                end
            end else if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: got=%h expected=no output", instruction);
            end else begin
                item_t it;
                it = exp_q.pop_front();
                check("instruction", instruction, it.instr);
                check("stall_cycles", stall_cnt, it.stalls);
                check("mem_read_cycles", mem_cyc, it.mem_cycles);
                stall_cnt = 0;
                mem_cyc   = 0;
                done_cnt++;
            end
        end
    end

    // Call at posedge+1; switch_after >= 0 moves PC to pc2 after that many edges.
    task automatic fetch(input logic [31:0] pc, input logic [31:0] instr, input int stalls,
                         input int mcyc, input logic [27:0] a, input logic [27:0] b,
                         input logic [31:0] pc2 = 32'h0, input int switch_after = -1);
        item_t it;
        int    start;
        int    n;
        it.instr = instr; it.stalls = stalls; it.mem_cycles = mcyc;
        it.addr_a = a; it.addr_b = b;
        exp_q.push_back(it);
        PC    = pc;
        req   = 1'b1;
        start = done_cnt;
        n     = 0;
        while (done_cnt == start && n < 200) begin
            @(posedge CLK);
            #1;
            n++;
            if (n == switch_after) PC = pc2;
        end
        if (done_cnt == start) begin
            checks++;
            failures++;
            $display("FAIL fetch_timeout: got=no output expected=%h for pc %h", instr, pc);
            exp_q.delete();
            stall_cnt = 0;
            mem_cyc   = 0;
        end
        req = 1'b0;
    endtask

    initial begin
`ifdef ICACHE_STATS_EN
        logic [31:0] h0, m0;
`endif
        RESET = 1'b1;
        PC    = SENTINEL;
        #1;
        check("reset_instruction", instruction, NOP);
        check("reset_busywait", {31'b0, instruction_mem_busywait}, 32'd0);
        check("reset_mem_read", {31'b0, mem_read}, 32'd0);
        check("reset_mem_address", {4'h0, mem_address}, 32'd0);
        #11 RESET = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check("sentinel_busywait", {31'b0, instruction_mem_busywait}, 32'd0);
            check("sentinel_instruction", instruction, NOP);
            check("sentinel_mem_read", {31'b0, mem_read}, 32'd0);
        end
        @(posedge CLK);
        #1;
`ifdef ICACHE_STATS_EN
        m0 = miss_count;
`endif
        // Cold miss: 1 idle + 4 memory + 1 update stall cycles.
        fetch(32'h0, 32'hC0DE0000, 6, 4, 28'h0, 28'h0);
`ifdef ICACHE_STATS_EN
        h0 = hit_count;
`endif
        fetch(32'h4, 32'hC0DE0004, 0, 0, 28'h0, 28'h0);
        fetch(32'h8, 32'hC0DE0008, 0, 0, 28'h0, 28'h0);
        fetch(32'hC, 32'hC0DE000C, 0, 0, 28'h0, 28'h0);
`ifdef ICACHE_STATS_EN
        check("miss_count", miss_count - m0, 32'd1);
        check("hit_count", hit_count - h0, 32'd3);
`endif
        // Conflict on index 0 evicts line 0.
        fetch(32'h80, 32'hC0DE0080, 6, 4, 28'h8, 28'h8);
        fetch(32'h0, 32'hC0DE0000, 6, 4, 28'h0, 28'h0);
        // PC moves 0x10 -> 0x20 mid-refill: line 1 completes, then line 2 is fetched.
        fetch(32'h10, 32'hC0DE0020, 12, 8, 28'h1, 28'h2, 32'h20, 2);
        fetch(32'h10, 32'hC0DE0010, 0, 0, 28'h0, 28'h0);
        fetch(32'h20, 32'hC0DE0020, 0, 0, 28'h0, 28'h0);
        // Asynchronous reset in the middle of a refill.
        PC = 32'h30;
        @(posedge CLK);
        @(posedge CLK);
        #2;
        check("pre_reset_mem_read", {31'b0, mem_read}, 32'd1);
        RESET = 1'b1;
        #1;
        check("async_reset_mem_read", {31'b0, mem_read}, 32'd0);
        check("async_reset_busywait", {31'b0, instruction_mem_busywait}, 32'd0);
        check("async_reset_instruction", instruction, NOP);
        check("async_reset_mem_address", {4'h0, mem_address}, 32'd0);
        PC = SENTINEL;
        #1 RESET = 1'b0;
        @(posedge CLK);
        #1;
        check("post_reset_mem_read", {31'b0, mem_read}, 32'd0);
        check("post_reset_busywait", {31'b0, instruction_mem_busywait}, 32'd0);
        fetch(32'h0, 32'hC0DE0000, 6, 4, 28'h0, 28'h0);
        fetch(32'h10, 32'hC0DE0010, 6, 4, 28'h1, 28'h1);
        fetch(32'h14, 32'hC0DE0014, 0, 0, 28'h0, 28'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/instruction_cache.md
Name: instruction_cache

Overview:
- Direct-mapped, read-only instruction cache directly upstream of the instruction fetch stage.
- Takes the fetch stage's PC and returns the 32-bit instruction. On a miss it drives instruction_mem_busywait, which stalls the fetch stage's PC update.
- Refills one 128-bit line (4 words) from instruction memory through a read/busywait handshake.

Parameters:
- INDEX_BITS, 3: number of lines = 2^INDEX_BITS (default 8 lines, 128 B total).
- NOP_INSTR, 32'h00000013: instruction driven while stalled, in reset and for the sentinel PC.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RESET  input  1  asynchronous, active-high reset.
- PC  input  32  fetch address from the fetch stage; word aligned, PC[1:0] ignored.
- instruction  output  32  instruction for the decode stage.
- instruction_mem_busywait  output  1  stall request to the fetch stage; high while the addressed word is not available.
- mem_read  output  1  refill request to instruction memory.
- mem_address  output  28  line address to memory (PC[31:4] of the missing line).
- mem_readdata  input  128  refill line; word0 in bits [31:0].
- mem_busywait  input  1  memory busy; refill data valid in the cycle this is low while mem_read is high.

Behaviour:
- Address split:
  - offset = PC[3:2]
  - index = PC[4+INDEX_BITS-1:4]
  - tag = PC[31:4+INDEX_BITS] (25 bits at default)
- Storage per line: valid bit, tag, 128-bit data.
- Hit detection is combinational: hit = valid[index] && tag match.
- On a hit in IDLE: instruction = selected word, busywait = 0 in the same cycle. Zero-cycle hit latency.
- Sentinel address 32'hFFFFFFFC: the value PC holds after reset.
  - Treated as no-fetch: busywait = 0, instruction = NOP_INSTR.
  - No refill is started.
- FSM states: IDLE, MEM_READ, UPDATE.
- IDLE:
  - On a miss (non-sentinel), busywait goes high combinationally.
  - Next rising edge: latch miss index/tag, go to MEM_READ.
- MEM_READ:
  - mem_read = 1, mem_address = latched {tag,index}, busywait = 1.
  - Stay while mem_busywait = 1.
  - At the edge where mem_busywait = 0: capture mem_readdata and go to UPDATE.
- UPDATE (exactly 1 cycle):
  - mem_read = 0, busywait = 1.
  - At the next edge, write data, tag and valid=1 into the latched index, then go to IDLE.
- Back in IDLE: the current PC is re-evaluated and hits if unchanged.
- Miss-to-instruction latency: 1 (IDLE) + N (memory) + 1 (UPDATE) cycles.
- While busywait = 1, instruction = NOP_INSTR.
- PC change during MEM_READ/UPDATE: the refill completes for the latched address. Afterwards the new PC is looked up normally, possibly starting a new miss.
- A refill into an occupied index replaces the old line unconditionally. There is no write port and no coherence.
- mem_address is held stable for the whole MEM_READ state.
- Reset, asynchronous and at any time including mid-refill:
  - all valid bits cleared; state = IDLE
  - mem_read = 0, mem_address = 0, busywait = 0, instruction = NOP_INSTR
  - an in-flight memory response after reset is ignored
- Data/tag arrays are not reset; only valid bits are.

Optional Feature:
- Macro: ICACHE_STATS_EN.
- Defined:
  - Adds two output ports: hit_count[31:0] and miss_count[31:0], both reset to 0.
  - hit_count increments once per rising edge in IDLE with a hit on a non-sentinel PC.
  - miss_count increments once per IDLE→MEM_READ transition.
  - Both wrap from 32'hFFFFFFFF to 0.
- Not defined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset with PC=32'hFFFFFFFC -> busywait=0, instruction=32'h00000013, mem_read=0, and remains so for 5 cycles.
- PC=0x00000000 cold; memory with 3 busy cycles returns {w3,w2,w1,w0}:
  - busywait high immediately; mem_read=1, mem_address=0 for 4 cycles.
  - UPDATE 1 cycle, then busywait=0 and instruction=w0.
  - PC=0x4/0x8/0xC then hit with 0 stall cycles, instruction=w1/w2/w3.
- Conflict: fill PC=0x00000000, then PC=0x00000080 (same index 0, different tag) -> miss and refill. Return to 0x0 -> miss again (line evicted).
- PC changes 0x10→0x20 during MEM_READ -> refill completes for line 0x1 (mem_address=1 held). Then a new miss on mem_address=2; PC 0x10 afterwards hits.
- RESET pulsed in MEM_READ mid-busywait -> mem_read drops asynchronously, state IDLE. Previously filled lines miss again after reset.
- With ICACHE_STATS_EN: 1 cold miss followed by 3 sequential hits -> miss_count=1, hit_count=3.
